// File: rtl/exp2_pipe.sv
// exp2_pipe: pipelined power-of-two scaler, Z = M << E truncated to width bits,
// one shift stage per exponent bit with a valid/ready stream and overflow flag.
module exp2_pipe #(
  parameter int width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [width-1:0]         M_i,
  input  logic [$clog2(width)-1:0] E_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [width-1:0]         Z_o,
  output logic                     ovf_o
);
  localparam int ew = $clog2(width);
  localparam int RW = (ew > 1) ? (ew * (ew - 1)) / 2 : 1;

  // Offset of stage k's remaining-exponent field in the packed triangular store.
  function automatic int rem_base(input int k);
    return k * (ew - 1) - (k * (k - 1)) / 2;
  endfunction

  // Returns {ovf, data}: shift by 2^k when en, flagging any '1' pushed past the MSB.
  function automatic logic [width:0] shift_ovf(input logic [width-1:0] d,
                                               input logic en, input int k);
    int s;
    s = 1 << k;
    if (!en) return {1'b0, d};
    if (s >= width) return {|d, {width{1'b0}}};
    return {|(d >> (width - s)), d << s};
  endfunction

  logic [ew-1:0]    vld_p, ovf_p;
  logic [width-1:0] data_p [ew];
  logic [RW-1:0]    rem_p;

  logic [ew-1:0]    rdy, ld, vin, sin, ovf_nx;
  logic [width-1:0] data_nx [ew];
  logic [RW-1:0]    rem_nx, rem_en;

  if (ew == 1) begin : g_norem
    assign rem_nx = '0;
    assign rem_en = '0;
  end

  for (genvar k = 0; k < ew; k++) begin : g_stage
    logic [width-1:0] d_in;
    logic             o_in;
    logic [width:0]   step;

    if (k == 0) begin : g_first
      assign vin[k] = in_valid_i;
      assign sin[k] = E_i[0];
      assign d_in   = M_i;
      assign o_in   = 1'b0;
    end else begin : g_next
      assign vin[k] = vld_p[k-1];
      assign sin[k] = rem_p[rem_base(k-1)];
      assign d_in   = data_p[k-1];
      assign o_in   = ovf_p[k-1];
    end

    // Closed form of ready_k = !valid_k || ready_{k+1}, avoiding a comb loop.
    assign rdy[k]     = out_ready_i | ~(&vld_p[ew-1:k]);
    assign ld[k]      = rdy[k] & vin[k] & ~clr_i;
    assign step       = shift_ovf(d_in, sin[k], k);
    assign data_nx[k] = step[width-1:0];
    assign ovf_nx[k]  = o_in | step[width];

    if (k < ew - 1) begin : g_rem
      localparam int B = rem_base(k);
      localparam int W = ew - 1 - k;
      assign rem_en[B +: W] = {W{ld[k]}};
      if (k == 0) begin : g_rem_first
        assign rem_nx[B +: W] = E_i[ew-1:1];
      end else begin : g_rem_next
        assign rem_nx[B +: W] = rem_p[rem_base(k-1) + 1 +: W];
      end
    end
  end

  // Stage registers: data only moves with a real operand, so bubbles never disturb Z_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p <= '0;
      ovf_p <= '0;
      rem_p <= '0;
      for (int k = 0; k < ew; k++) data_p[k] <= '0;
    end else begin
      for (int k = 0; k < ew; k++) begin
        if (clr_i) vld_p[k] <= 1'b0;
        else if (rdy[k]) vld_p[k] <= vin[k];
        if (ld[k]) begin
          data_p[k] <= data_nx[k];
          ovf_p[k]  <= ovf_nx[k];
        end
      end
      for (int i = 0; i < RW; i++) begin
        if (rem_en[i]) rem_p[i] <= rem_nx[i];
      end
    end
  end

  assign in_ready_o  = rdy[0];
  assign out_valid_o = vld_p[ew-1];
  assign Z_o         = data_p[ew-1];
  assign ovf_o       = ovf_p[ew-1];

endmodule

// File: tb/tb_exp2_pipe.sv
// Bench for exp2_pipe: queue-based reference model checked every cycle, plus
// directed vectors with literal expectations at width 8 and width 6.
module tb_exp2_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready_r = 1'b1;
  logic       rand_bp = 1'b0;
  logic       bp_bit = 1'b1;
  logic       out_ready;
  logic       in_ready, out_valid, ovf;
  logic [7:0] M = '0;
  logic [7:0] Z;
  logic [2:0] E = '0;

  logic       in6_valid = 1'b0;
  logic       out6_ready = 1'b1;
  logic       clr6 = 1'b0;
  logic       in6_ready, out6_valid, ovf6;
  logic [5:0] M6 = '0;
  logic [5:0] Z6;
  logic [2:0] E6 = '0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  assign out_ready = rand_bp ? bp_bit : out_ready_r;

  exp2_pipe #(.width(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .M_i(M), .E_i(E),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .Z_o(Z), .ovf_o(ovf)
  );

  exp2_pipe #(.width(6)) dut6 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr6),
    .in_valid_i(in6_valid), .in_ready_o(in6_ready), .M_i(M6), .E_i(E6),
    .out_valid_o(out6_valid), .out_ready_i(out6_ready), .Z_o(Z6), .ovf_o(ovf6)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    bp_bit = 1'($urandom_range(0, 1));
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: exact product M * 2^E, low byte is Z, anything above is overflow.
  function automatic logic [8:0] model8(input logic [7:0] m, input logic [2:0] e);
    logic [15:0] full;
    full = 16'(m) * (16'd1 << e);
    return {full[15:8] != 8'd0, full[7:0]};
  endfunction

  logic [7:0] qz[$];
  logic       qo[$];
  int         qc[$];
  logic [7:0] log_z[$];
  logic       log_o[$];
  int         log_c[$];
  int         log_lat[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_z = '0;
  logic       prev_o = 1'b0;
  logic [8:0] mon_m;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      qz.delete(); qo.delete(); qc.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(out_ready || (qz.size() < 3)));
      if (prev_stall) begin
        chk("hold_vld", 32'(out_valid), 32'd1);
        chk("hold_z", 32'(Z), 32'(prev_z));
        chk("hold_ovf", 32'(ovf), 32'(prev_o));
      end
      if (qz.size() == 0) chk("idle_vld", 32'(out_valid), 32'd0);
      if (clr) begin
        qz.delete(); qo.delete(); qc.delete();
      end else begin
        if (out_valid && out_ready && qz.size() > 0) begin
          chk("z", 32'(Z), 32'(qz[0]));
          chk("ovf", 32'(ovf), 32'(qo[0]));
          log_z.push_back(Z);
          log_o.push_back(ovf);
          log_c.push_back(cyc);
          log_lat.push_back(cyc - qc[0]);
          void'(qz.pop_front()); void'(qo.pop_front()); void'(qc.pop_front());
        end
        if (in_valid && in_ready) begin
          mon_m = model8(M, E);
          qz.push_back(mon_m[7:0]);
          qo.push_back(mon_m[8]);
          qc.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready && !clr;
      prev_z = Z;
      prev_o = ovf;
    end
  end

  task automatic send(input logic [7:0] m, input logic [2:0] e);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; M = m; E = e;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && qz.size() > 0; t++) @(negedge clk);
    if (qz.size() > 0) chk("drain_timeout", 32'(qz.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run6(input logic [5:0] m, input logic [2:0] e,
                      input logic [5:0] ez, input logic eo, input string name);
    logic ok;
    ok = 1'b0;
    in6_valid = 1'b1; M6 = m; E6 = e;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = in6_ready;
    end
    @(posedge clk); #1;
    in6_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = out6_valid;
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({name, "_z"}, 32'(Z6), 32'(ez));
      chk({name, "_ovf"}, 32'(ovf6), 32'(eo));
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] onehot_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  int b;
  int last;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_z", 32'(Z), 32'h00);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("model_a", 32'(model8(8'h16, 3'd2)), 32'h058);
    chk("model_b", 32'(model8(8'h16, 3'd4)), 32'h160);
    chk("model_c", 32'(model8(8'h00, 3'd7)), 32'h000);
    chk("model_d", 32'(model8(8'h01, 3'd7)), 32'h080);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_rdy", 32'(in_ready), 32'd1);

    // One-hot decode, back to back.
    b = log_z.size();
    for (int i = 0; i < 8; i++) send(8'h01, 3'(i));
    drain();
    chk("onehot_cnt", 32'(log_z.size() - b), 32'd8);
    if (log_z.size() >= b + 8) begin
      chk("onehot_lat", 32'(log_lat[b]), 32'd3);
      for (int i = 0; i < 8; i++) begin
        chk("onehot_z", 32'(log_z[b+i]), 32'(onehot_tab[i]));
        chk("onehot_ovf", 32'(log_o[b+i]), 32'd0);
        chk("onehot_seq", 32'(log_c[b+i] - log_c[b]), 32'(i));
        chk("onehot_log2", 32'($clog2(log_z[b+i])), 32'(i));
      end
    end

    // Scaling and overflow.
    b = log_z.size();
    send(8'h16, 3'd2);
    send(8'h16, 3'd4);
    send(8'h00, 3'd7);
    drain();
    chk("scale_cnt", 32'(log_z.size() - b), 32'd3);
    if (log_z.size() >= b + 3) begin
      chk("scale0_z", 32'(log_z[b]), 32'h58);
      chk("scale0_ovf", 32'(log_o[b]), 32'd0);
      chk("scale1_z", 32'(log_z[b+1]), 32'h60);
      chk("scale1_ovf", 32'(log_o[b+1]), 32'd1);
      chk("zero_z", 32'(log_z[b+2]), 32'h00);
      chk("zero_ovf", 32'(log_o[b+2]), 32'd0);
    end

    // Random backpressure.
    b = log_z.size();
    rand_bp = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(i * 37 + 5), 3'(i % 8));
    drain();
    rand_bp = 1'b0;
    out_ready_r = 1'b1;
    chk("bp_cnt", 32'(log_z.size() - b), 32'd10);

    // Clear with three in flight and an input offered in the same cycle.
    b = log_z.size();
    send(8'h11, 3'd1);
    send(8'h22, 3'd2);
    send(8'h33, 3'd3);
    in_valid = 1'b1; M = 8'hFF; E = 3'd1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("clr_none", 32'(log_z.size() - b), 32'd0);
    send(8'h03, 3'd1);
    drain();
    chk("clr_next_cnt", 32'(log_z.size() - b), 32'd1);
    if (log_z.size() > b) begin
      last = log_z.size() - 1;
      chk("clr_next_z", 32'(log_z[last]), 32'h06);
      chk("clr_next_ovf", 32'(log_o[last]), 32'd0);
      chk("clr_next_lat", 32'(log_lat[last]), 32'd3);
    end

    // Odd width.
    run6(6'h01, 3'd6, 6'h00, 1'b1, "w6_e6");
    run6(6'h21, 3'd1, 6'h02, 1'b1, "w6_21");
    run6(6'h05, 3'd2, 6'h14, 1'b0, "w6_05");

    // Reset mid-stream while a result is stalled at the output.
    out_ready_r = 1'b0;
    send(8'h05, 3'd1);
    send(8'h07, 3'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_z", 32'(Z), 32'h00);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_r = 1'b1;
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
    chk("post_rst_vld", 32'(out_valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
